// File: rtl/synchronous_fifo.sv
// rtl/synchronous_fifo.sv - single-clock FIFO with registered status flags
//
// Purpose: single-clock first-in first-out buffer. All flags, fill_count and the
//          overflow/underflow pulses come from registers, updated on the edge of
//          the access that changes them.
// Config macro: SYNC_FIFO_FWFT_EN selects first-word fall-through read_data.
//               Without it, read_data is a register loaded on each accepted read.
// Ports:
//   clk          in   clock, all state changes on its rising edge
//   reset_n      in   asynchronous active-low reset
//   w_en         in   write request
//   r_en         in   read request
//   write_data   in   [DATA_LENGTH-1:0] entry to store
//   read_data    out  [DATA_LENGTH-1:0] entry read out
//   fifo_full    out  fill level == NUM_ADDRESS
//   fifo_empty   out  fill level == 0
//   almost_full  out  fill level >= ALMOST_FULL_LEVEL
//   almost_empty out  fill level <= ALMOST_EMPTY_LEVEL
//   fill_count   out  [$clog2(NUM_ADDRESS):0] stored entries
//   overflow     out  one-cycle pulse on a rejected write
//   underflow    out  one-cycle pulse on a rejected read

module synchronous_fifo #(
  parameter int NUM_ADDRESS        = 8,
  parameter int DATA_LENGTH        = 32,
  parameter int ALMOST_FULL_LEVEL  = NUM_ADDRESS - 2,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          w_en,
  input  logic                          r_en,
  input  logic [DATA_LENGTH-1:0]        write_data,
  output logic [DATA_LENGTH-1:0]        read_data,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [$clog2(NUM_ADDRESS):0]  fill_count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(NUM_ADDRESS);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_LVL = CW'(NUM_ADDRESS);
  localparam logic [CW-1:0] AF_LVL   = CW'(ALMOST_FULL_LEVEL);
  localparam logic [CW-1:0] AE_LVL   = CW'(ALMOST_EMPTY_LEVEL);

  logic [DATA_LENGTH-1:0] mem [NUM_ADDRESS];

  // Pointers carry one extra wrap bit so their difference spans 0..NUM_ADDRESS.
  logic [CW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] wr_ptr_nxt, rd_ptr_nxt, cnt_nxt;
  logic          wr_acc, rd_acc;

  always_comb begin
    wr_acc     = w_en & ~fifo_full;
    rd_acc     = r_en & ~fifo_empty;
    wr_ptr_nxt = wr_ptr + CW'(wr_acc);
    rd_ptr_nxt = rd_ptr + CW'(rd_acc);
    cnt_nxt    = wr_ptr_nxt - rd_ptr_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill_count   <= '0;
      fifo_full    <= 1'b0;
      fifo_empty   <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      fill_count   <= cnt_nxt;
      fifo_full    <= (cnt_nxt == FULL_LVL);
      fifo_empty   <= (cnt_nxt == '0);
      almost_full  <= (cnt_nxt >= AF_LVL);
      almost_empty <= (cnt_nxt <= AE_LVL);
      // A simultaneous request at a boundary is serviced on the other side
      // (read at full, write at empty), so it is not reported as an error.
      overflow     <= w_en & fifo_full & ~r_en;
      underflow    <= r_en & fifo_empty & ~w_en;
    end
  end

  // Storage is never cleared; the reset pointers make stale entries unreachable.
  // Writes are held off while reset is asserted so no access completes then.
  always_ff @(posedge clk) begin
    if (reset_n && wr_acc) begin
      mem[wr_ptr[AW-1:0]] <= write_data;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head entry is visible as soon as the FIFO is non-empty; r_en just pops it.
  assign read_data = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_data <= '0;
    end else if (rd_acc) begin
      read_data <= mem[rd_ptr[AW-1:0]];
    end
  end
`endif

endmodule

// File: tb/tb_synchronous_fifo.sv
// tb/tb_synchronous_fifo.sv - self-checking bench for synchronous_fifo
//
// Purpose: table-driven vectors, hand-written corner sequences and random
//          traffic, all compared against a queue-based reference model.
// Config macro: SYNC_FIFO_FWFT_EN changes the expected read_data behaviour.

module tb_synchronous_fifo;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        w_en, r_en;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        fifo_full, fifo_empty, almost_full, almost_empty;
  logic [3:0]  fill_count;
  logic        overflow, underflow;

  always #5 clk = ~clk;

  synchronous_fifo #(
    .NUM_ADDRESS       (8),
    .DATA_LENGTH       (32),
    .ALMOST_FULL_LEVEL (6),
    .ALMOST_EMPTY_LEVEL(2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .w_en        (w_en),
    .r_en        (r_en),
    .write_data  (write_data),
    .read_data   (read_data),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .fill_count  (fill_count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: contents as a queue, plus the last value popped.
  logic [31:0] q[$];
  logic [31:0] m_rd;
  bit          m_ov, m_un;

  typedef struct {
    bit          w;
    bit          r;
    logic [31:0] d;
    int          cnt;
    bit          ov;
    bit          un;
    logic [31:0] rd_reg;
    logic [31:0] rd_fwft;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd();
`ifdef SYNC_FIFO_FWFT_EN
    return (q.size() != 0) ? q[0] : 32'h0;
`else
    return m_rd;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_rd = '0;
    m_ov = 1'b0;
    m_un = 1'b0;
  endtask

  task automatic model_edge(input bit w, input bit r, input logic [31:0] d);
    bit full, empty;
    full  = (q.size() == N);
    empty = (q.size() == 0);
    m_ov  = w && full && !r;
    m_un  = r && empty && !w;
    if (r && !empty) m_rd = q.pop_front();
    if (w && !full)  q.push_back(d);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, fill_count,   q.size());
    chk({tag, ".full"},  fifo_full,    q.size() == N);
    chk({tag, ".empty"}, fifo_empty,   q.size() == 0);
    chk({tag, ".afull"}, almost_full,  q.size() >= 6);
    chk({tag, ".aempty"},almost_empty, q.size() <= 2);
    chk({tag, ".ovf"},   overflow,     m_ov);
    chk({tag, ".unf"},   underflow,    m_un);
    chk({tag, ".rdata"}, read_data,    exp_rd());
  endtask

  // Called just after a falling edge: drive, let one rising edge pass, check.
  task automatic cycle(input string tag, input bit w, input bit r, input logic [31:0] d);
    w_en       = w;
    r_en       = r;
    write_data = d;
    @(posedge clk);
    model_edge(w, r, d);
    @(negedge clk);
    w_en = 1'b0;
    r_en = 1'b0;
    check_all(tag);
  endtask

  task automatic drain();
    for (int i = 0; i < N + 2; i++) begin
      if (q.size() != 0) cycle("drain", 1'b0, 1'b1, 32'h0);
    end
  endtask

  // Reset pulse between clock edges; checks the asynchronous clear.
  task automatic reset_pulse(input string tag);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk({tag, ".empty"},  fifo_empty,   1'b1);
    chk({tag, ".count"},  fill_count,   4'd0);
    chk({tag, ".full"},   fifo_full,    1'b0);
    chk({tag, ".aempty"}, almost_empty, 1'b1);
    chk({tag, ".rdata"},  read_data,    32'h0);
    #1 reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset_n    = 1'b0;
    w_en       = 1'b0;
    r_en       = 1'b0;
    write_data = '0;
    model_reset();

    tbl[0] = '{1'b1, 1'b0, 32'hDEADFADE, 1, 1'b0, 1'b0, 32'h0,        32'hDEADFADE};
    tbl[1] = '{1'b1, 1'b0, 32'hFADED000, 2, 1'b0, 1'b0, 32'h0,        32'hDEADFADE};
    tbl[2] = '{1'b0, 1'b1, 32'h0,        1, 1'b0, 1'b0, 32'hDEADFADE, 32'hFADED000};
    tbl[3] = '{1'b0, 1'b1, 32'h0,        0, 1'b0, 1'b0, 32'hFADED000, 32'h0};
    tbl[4] = '{1'b0, 1'b1, 32'h0,        0, 1'b0, 1'b1, 32'hFADED000, 32'h0};
    tbl[5] = '{1'b1, 1'b1, 32'h11111111, 1, 1'b0, 1'b0, 32'hFADED000, 32'h11111111};
    tbl[6] = '{1'b0, 1'b1, 32'h0,        0, 1'b0, 1'b0, 32'h11111111, 32'h0};

    // Reset state
    repeat (2) @(negedge clk);
    check_all("reset");
    chk("reset.empty_const", fifo_empty, 1'b1);
    reset_n = 1'b1;

    // Table-driven vectors: ordering, underflow, simultaneous access at empty
    for (int i = 0; i < 7; i++) begin
      cycle($sformatf("vec%0d", i), tbl[i].w, tbl[i].r, tbl[i].d);
      chk($sformatf("vec%0d.tcount", i), fill_count, tbl[i].cnt);
      chk($sformatf("vec%0d.tovf", i), overflow, tbl[i].ov);
      chk($sformatf("vec%0d.tunf", i), underflow, tbl[i].un);
`ifdef SYNC_FIFO_FWFT_EN
      chk($sformatf("vec%0d.trdata", i), read_data, tbl[i].rd_fwft);
`else
      chk($sformatf("vec%0d.trdata", i), read_data, tbl[i].rd_reg);
`endif
    end

    // Reset mid-stream, then a read underflows with read_data 0
    cycle("mid_w0", 1'b1, 1'b0, 32'hA5A5A5A5);
    cycle("mid_w1", 1'b1, 1'b0, 32'hDEADBABE);
    reset_pulse("mid_rst");
    cycle("mid_rd", 1'b0, 1'b1, 32'h0);
    chk("mid_rd.unf_const", underflow, 1'b1);
    chk("mid_rd.rd_const", read_data, 32'h0);

    // Write accepted on the first edge after reset release
    cycle("pre_w", 1'b1, 1'b0, 32'h0BADF00D);
    reset_pulse("rst2");
    cycle("post_w", 1'b1, 1'b0, 32'hCAFE0001);
    chk("post_w.count_const", fill_count, 4'd1);
    drain();

    // Fill to full, overflow, then simultaneous access at full
    for (int i = 1; i <= N; i++) begin
      cycle($sformatf("fill%0d", i), 1'b1, 1'b0, 32'hFADEFADE);
      chk($sformatf("fill%0d.ae_const", i), almost_empty, i <= 2);
      chk($sformatf("fill%0d.af_const", i), almost_full, i >= 6);
      chk($sformatf("fill%0d.full_const", i), fifo_full, i == N);
    end
    chk("fill8.count_const", fill_count, 4'd8);
    cycle("ovf", 1'b1, 1'b0, 32'h99999999);
    chk("ovf.pulse_const", overflow, 1'b1);
    chk("ovf.count_const", fill_count, 4'd8);
    cycle("ovf_idle", 1'b0, 1'b0, 32'h0);
    chk("ovf_idle.pulse_const", overflow, 1'b0);
    cycle("full_wr", 1'b1, 1'b1, 32'h55555555);
    chk("full_wr.count_const", fill_count, 4'd7);
    chk("full_wr.ovf_const", overflow, 1'b0);
    drain();
    cycle("empty_wr", 1'b1, 1'b1, 32'h66666666);
    chk("empty_wr.count_const", fill_count, 4'd1);
    chk("empty_wr.unf_const", underflow, 1'b0);
    drain();

    // Wrap-around with concurrent write/read
    cycle("wrap_pre", 1'b1, 1'b0, 32'h0);
    for (int i = 1; i <= 20; i++) begin
      cycle($sformatf("wrap%0d", i), 1'b1, 1'b1, 32'(i));
      chk($sformatf("wrap%0d.count_const", i), fill_count, 4'd1);
`ifdef SYNC_FIFO_FWFT_EN
      chk($sformatf("wrap%0d.rd_const", i), read_data, 32'(i));
`else
      chk($sformatf("wrap%0d.rd_const", i), read_data, 32'(i - 1));
`endif
    end
    drain();

`ifdef SYNC_FIFO_FWFT_EN
    cycle("fwft_w", 1'b1, 1'b0, 32'h12345678);
    chk("fwft_w.rd_const", read_data, 32'h12345678);
    drain();
`endif

    // Random traffic: phases biased toward filling and draining
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 100; i++) begin
        bit w, r;
        w = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 75 : 30));
        r = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 30 : 75));
        cycle($sformatf("rnd%0d_%0d", ph, i), w, r, $urandom);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
